btn_debounce_multi: RTL and testbench

BTN_DEBOUNCE_MULTI -- requirements
Module: btn_debounce_multi

---
 rtl/btn_debounce_multi.sv | 85 ++++++++
 tb/tb_btn_debounce_multi.sv | 91 +++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: per-channel synchronized, tick-sampled button debouncer with edge pulses; auto-repeat enabled by BTN_DEBOUNCE_AUTOREPEAT_EN
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8,
  parameter int HOLD_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_rpt,
  output logic            o_tick
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  logic [TW-1:0]   tcnt;
  logic [N_CH-1:0] s1, s2, tgl;
  logic [SW-1:0]   stab [N_CH];
  assign o_tick = tcnt == TW'(TICK_DIV - 1);
  // free-running sample tick divider and two-flop input synchronizer
  always_ff @(posedge clk)
    if (rst) begin
      tcnt <= '0;
      s1   <= '0;
      s2   <= '0;
    end else begin
      tcnt <= o_tick ? '0 : tcnt + 1'b1;
      s1   <= i_btn;
      s2   <= s1;
    end
  // a channel flips on the tick whose differing sample completes the stable run
  always_comb begin
    tgl = '0;
    for (int c = 0; c < N_CH; c++)
      tgl[c] = o_tick && s2[c] != o_level[c] && stab[c] == SW'(STABLE_TICKS - 1);
  end
  // stability counting, debounced level and registered edge pulses
  always_ff @(posedge clk)
    if (rst) begin
      for (int c = 0; c < N_CH; c++) stab[c] <= '0;
      o_level <= '0;
      o_rise  <= '0;
      o_fall  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (o_tick) stab[c] <= (s2[c] != o_level[c] && !tgl[c]) ? stab[c] + 1'b1 : '0;
      o_level <= o_level ^ tgl;
      o_rise  <= tgl & ~o_level;
      o_fall  <= tgl & o_level;
    end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int HMAX = HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);
  logic [HW-1:0]   hold [N_CH];
  logic [N_CH-1:0] rep;
  // held ticks count toward HOLD_TICKS first, then toward each REPEAT_TICKS interval
  always_ff @(posedge clk)
    if (rst) begin
      for (int c = 0; c < N_CH; c++) hold[c] <= '0;
      rep   <= '0;
      o_rpt <= '0;
    end else begin
      o_rpt <= '0;
      for (int c = 0; c < N_CH; c++)
        if (!o_level[c] || tgl[c]) begin
          hold[c] <= '0;
          rep[c]  <= 1'b0;
        end else if (o_tick) begin
          if (hold[c] == HW'(rep[c] ? REPEAT_TICKS - 1 : HOLD_TICKS - 1)) begin
            hold[c]  <= '0;
            rep[c]   <= 1'b1;
            o_rpt[c] <= 1'b1;
          end else hold[c] <= hold[c] + 1'b1;
        end
    end
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_TICKS, REPEAT_TICKS};
  assign o_rpt = '0;
`endif
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed vector check of btn_debounce_multi with small timing parameters
module tb_btn_debounce_multi;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [1:0] o_level, o_rise, o_fall, o_rpt;
  logic       o_tick;
  int         n_vec = 0, n_err = 0;
  btn_debounce_multi #(.N_CH(2), .TICK_DIV(4), .STABLE_TICKS(3), .HOLD_TICKS(10), .REPEAT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .i_btn(btn), .o_level(o_level), .o_rise(o_rise),
    .o_fall(o_fall), .o_rpt(o_rpt), .o_tick(o_tick)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       rst;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       tick;
  } vec_t;
  vec_t tbl [21];
  task automatic check(input string nm, input int e, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, got, exp);
    end
  endtask
  initial begin
    logic [1:0] el, er, ef, ep;
    logic       et;
    // edge index: {rst, btn, level, rise, fall, tick} after that rising edge
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[9]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[13] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[14] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[15] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[16] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
    tbl[17] = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0};
    tbl[18] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[19] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    tbl[20] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
    for (int k = 0; k < 21; k++) begin
      rst = tbl[k].rst;
      btn = tbl[k].btn;
      @(posedge clk);
      @(negedge clk);
      check("table", k, {1'b0, o_level, o_rise, o_fall, o_tick},
            {1'b0, tbl[k].lvl, tbl[k].rise, tbl[k].fall, tbl[k].tick});
      check("table_rpt", k, {6'd0, o_rpt}, 8'd0);
    end
    // hold/repeat and release on ch0, bounce on ch0, dual press/release, reset mid-press
    for (int e = 21; e <= 290; e++) begin
      rst = (e == 270);
      btn = (e <= 137) ? 2'b01 :
            ((e >= 161 && e <= 165) || (e >= 171 && e <= 175)) ? 2'b01 :
            (e >= 202 && e <= 229) ? 2'b11 :
            (e >= 251) ? 2'b01 : 2'b00;
      @(posedge clk);
      @(negedge clk);
      el = (e <= 148) ? 2'b01 :
           (e >= 213 && e <= 240) ? 2'b11 :
           ((e >= 261 && e <= 269) || e >= 282) ? 2'b01 : 2'b00;
      er = (e == 213) ? 2'b11 : (e == 261 || e == 282) ? 2'b01 : 2'b00;
      ef = (e == 149) ? 2'b01 : (e == 241) ? 2'b11 : 2'b00;
      et = (e < 270) ? (e % 4 == 0) : (e >= 273 && (e - 273) % 4 == 0);
      ep = (AR && (e inside {57, 73, 89, 105, 121, 137})) ? 2'b01 : 2'b00;
      check(e < 161 ? "hold" : e < 201 ? "bounce" : e < 251 ? "dual" : "reset",
            e, {1'b0, o_level, o_rise, o_fall, o_tick}, {1'b0, el, er, ef, et});
      check("rpt", e, {6'd0, o_rpt}, {6'd0, ep});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
